// File: rtl/uart_pixel_loader.sv
// uart_pixel_loader: turns the UART receiver's byte stream into frame-buffer
// pixel writes. Packet: HEADER, ADDR_H, ADDR_L, DATA (+ CHK when the
// UART_PIXEL_CHK_EN macro is defined, CHK = ADDR_H ^ ADDR_L ^ DATA).
// Malformed packets (inter-byte timeout, address out of range, bad checksum)
// are dropped with a one-cycle err pulse and a held err_code.
`timescale 1ns/1ps

module uart_pixel_loader #(
    parameter int          PIXELS      = 19200,
    parameter int          ADDR_W      = 16,
    parameter logic [7:0]  HEADER      = 8'h55,
    parameter int          TIMEOUT_CYC = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [15:0]       pkt_cnt
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] ERR_TIMEOUT = 2'd0;
    localparam logic [1:0] ERR_RANGE   = 2'd1;
`ifdef UART_PIXEL_CHK_EN
    localparam logic [1:0] ERR_CHK     = 2'd2;
`endif

    typedef enum logic [2:0] {
        IDLE,
        GET_AH,
        GET_AL,
        GET_DATA,
`ifdef UART_PIXEL_CHK_EN
        GET_CHK,
`endif
        COMMIT
    } state_t;

    state_t            state_q;
    logic [TMO_W-1:0]  tmo_q;
    logic [7:0]        ah_q;
    logic [7:0]        al_q;
`ifdef UART_PIXEL_CHK_EN
    logic [7:0]        data_q;
`endif
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;
    logic              busy_q;
    logic              err_q;
    logic [1:0]        err_code_q;
    logic [15:0]       pkt_cnt_q;

    logic              tmo_hit;
    logic              last_byte;
    logic              chk_ok;
    logic              addr_ok;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [7:0]        wr_data_d;

    assign tmo_hit   = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
    assign wr_addr_d = ADDR_W'({ah_q, al_q});
    assign addr_ok   = (32'(wr_addr_d) < 32'(PIXELS));

    // Identify the byte that completes a packet and what it would commit.
    // NOTE: every signal gets a default before the build-dependent overrides,
    // so no path through this block can leave a value unassigned (no latch).
    always_comb begin
        last_byte = 1'b0;
        chk_ok    = 1'b1;
        wr_data_d = rx_data;
`ifdef UART_PIXEL_CHK_EN
        last_byte = (state_q == GET_CHK) && rx_valid;
        chk_ok    = (rx_data == (ah_q ^ al_q ^ data_q));
        wr_data_d = data_q;
`else
        last_byte = (state_q == GET_DATA) && rx_valid;
`endif
    end

    // Packet FSM with registered outputs and the inter-byte timeout counter.
    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tmo_q      <= '0;
            ah_q       <= '0;
            al_q       <= '0;
`ifdef UART_PIXEL_CHK_EN
            data_q     <= '0;
`endif
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            wr_en_q <= 1'b0;
            err_q   <= 1'b0;

            // Any accepted byte restarts the inter-byte window.
            if (rx_valid || state_q == IDLE) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + TMO_W'(1);
            end

            if (tmo_hit && !rx_valid && state_q != IDLE && state_q != COMMIT) begin
                // Sender stalled mid-packet: drop what was collected.
                state_q    <= IDLE;
                busy_q     <= 1'b0;
                err_q      <= 1'b1;
                err_code_q <= ERR_TIMEOUT;
            end else if (last_byte) begin
                if (!chk_ok) begin
`ifdef UART_PIXEL_CHK_EN
                    state_q    <= IDLE;
                    busy_q     <= 1'b0;
                    err_q      <= 1'b1;
                    err_code_q <= ERR_CHK;
`endif
                end else begin
                    // COMMIT lasts one cycle; its outputs are loaded on entry.
                    state_q <= COMMIT;
                    busy_q  <= 1'b1;
                    if (addr_ok) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= wr_addr_d;
                        wr_data_q <= wr_data_d;
                        pkt_cnt_q <= pkt_cnt_q + 16'd1;
                    end else begin
                        err_q      <= 1'b1;
                        err_code_q <= ERR_RANGE;
                    end
                end
            end else begin
                case (state_q)
                    // COMMIT behaves like IDLE so a header arriving there is kept.
                    IDLE, COMMIT: begin
                        if (rx_valid && rx_data == HEADER) begin
                            state_q <= GET_AH;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    GET_AH: begin
                        if (rx_valid) begin
                            ah_q    <= rx_data;
                            state_q <= GET_AL;
                        end
                    end
                    GET_AL: begin
                        if (rx_valid) begin
                            al_q    <= rx_data;
                            state_q <= GET_DATA;
                        end
                    end
`ifdef UART_PIXEL_CHK_EN
                    GET_DATA: begin
                        if (rx_valid) begin
                            data_q  <= rx_data;
                            state_q <= GET_CHK;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign err      = err_q;
    assign err_code = err_code_q;
    assign pkt_cnt  = pkt_cnt_q;

endmodule

// File: tb/tb_uart_pixel_loader.sv
// Testbench for uart_pixel_loader: directed packets plus randomized byte
// streams. A packet-level reference model predicts every write / drop and
// pushes it to a queue; a monitor pops and compares on each wr_en or err.
`timescale 1ns/1ps

module tb_uart_pixel_loader;

    localparam int         PIXELS      = 19200;
    localparam int         ADDR_W      = 16;
    localparam logic [7:0] HEADER      = 8'h55;
    localparam int         TIMEOUT_CYC = 1000;
`ifdef UART_PIXEL_CHK_EN
    localparam bit CHK = 1'b1;
    localparam int NB  = 5;
`else
    localparam bit CHK = 1'b0;
    localparam int NB  = 4;
`endif

    logic              clk;
    logic              rst;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              busy;
    logic              err;
    logic [1:0]        err_code;
    logic [15:0]       pkt_cnt;

    uart_pixel_loader #(
        .PIXELS      (PIXELS),
        .ADDR_W      (ADDR_W),
        .HEADER      (HEADER),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .err      (err),
        .err_code (err_code),
        .pkt_cnt  (pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_mis = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // ---------------- reference model (packet level) ----------------
    typedef struct {
        bit is_err;
        int code;
        int addr;
        int data;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   pkt[$];
    int   last_cyc = 0;
    int   exp_cnt  = 0;

    function automatic void push_err(int code);
        exp_q.push_back('{1'b1, code, 0, 0, exp_cnt});
    endfunction

    // A partial packet whose next byte would arrive more than TIMEOUT_CYC
    // cycles after the previous one is dropped as a timeout.
    function automatic void model_time(int now);
        if (pkt.size() > 0 && now - last_cyc > TIMEOUT_CYC) begin
            push_err(0);
            pkt.delete();
        end
    endfunction

    function automatic void model_byte(int b, int now);
        int addr;
        model_time(now);
        if (pkt.size() == 0) begin
            if (b == HEADER) pkt.push_back(b);
        end else begin
            pkt.push_back(b);
        end
        last_cyc = now;
        if (pkt.size() == NB) begin
            addr = pkt[1] * 256 + pkt[2];
            if (CHK && pkt[NB-1] != (pkt[1] ^ pkt[2] ^ pkt[3])) begin
                push_err(2);
            end else if (addr >= PIXELS) begin
                push_err(1);
            end else begin
                exp_cnt = (exp_cnt + 1) % 65536;
                exp_q.push_back('{1'b0, 0, addr, pkt[3], exp_cnt});
            end
            pkt.delete();
        end
    endfunction

    // ---------------- monitor ----------------
    exp_t e;
    bit   busy_pend = 1'b0;
    bit   busy_exp  = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            busy_pend = 1'b0;
        end else begin
            if (busy_pend) begin
                check("busy_after_event", 32'(busy), 32'(busy_exp));
                busy_pend = 1'b0;
            end
            if (wr_en || err) begin
                check("wr_en_err_exclusive", 32'(wr_en & err), 0);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_mis++;
                    $display("FAIL unexpected_event: wr_en=%0b err=%0b code=%0d addr=%0d data=0x%0h, none predicted at cycle %0d",
                             wr_en, err, err_code, wr_addr, wr_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("event_is_err", 32'(err), 32'(e.is_err));
                    check("event_is_wr", 32'(wr_en), 32'(!e.is_err));
                    if (e.is_err) begin
                        check("err_code", 32'(err_code), 32'(e.code));
                        check("busy_on_err", 32'(busy), 32'(e.code == 1));
                    end else begin
                        check("wr_addr", 32'(wr_addr), 32'(e.addr));
                        check("wr_data", 32'(wr_data), 32'(e.data));
                        check("busy_on_wr", 32'(busy), 1);
                    end
                    check("pkt_cnt", 32'(pkt_cnt), 32'(e.cnt));
                end
                // Next cycle the FSM is idle unless a header lands right now.
                busy_pend = 1'b1;
                busy_exp  = rx_valid && (rx_data == HEADER);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        model_byte(int'(b), cyc + 1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic idle(input int n);
        model_time(cyc + n + 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_pkt(input logic [7:0] ah, input logic [7:0] al, input logic [7:0] d,
                            input int gap, input bit corrupt);
        logic [7:0] c;
        c = ah ^ al ^ d;
        if (corrupt) c = ~c;
        send_byte(HEADER); idle(gap);
        send_byte(ah);     idle(gap);
        send_byte(al);     idle(gap);
        send_byte(d);      idle(gap);
        if (CHK) begin
            send_byte(c);
            idle(gap);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pkt.delete();
        exp_cnt = 0;
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        check("rst_err_code", 32'(err_code), 0);
        check("rst_pkt_cnt", 32'(pkt_cnt), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         r;
        int         g;
        int         k;
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  b;

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        do_reset();

        // Basic write: addr 300, data E3.
        send_pkt(8'h01, 8'h2C, 8'hE3, 31, 1'b0);
        // Leading junk byte ignored, then write addr 5.
        send_byte(8'h12); idle(31);
        send_pkt(8'h00, 8'h05, 8'h7F, 31, 1'b0);
        // Address 19200 is one past the end.
        send_pkt(8'h4B, 8'h00, 8'h11, 31, 1'b0);
        // Stall one cycle past the window, then a clean packet.
        send_byte(HEADER); idle(5); send_byte(8'h00);
        idle(TIMEOUT_CYC);
        send_pkt(8'h00, 8'h00, 8'hAA, 3, 1'b0);
        // Byte on exactly the terminal-count cycle is accepted.
        send_byte(HEADER); send_byte(8'h00);
        idle(TIMEOUT_CYC - 1);
        send_byte(8'h00); send_byte(8'hAA);
        if (CHK) send_byte(8'hAA);
        idle(5);
        // Wrong checksum.
        if (CHK) begin
            send_byte(HEADER); send_byte(8'h00); send_byte(8'h01);
            send_byte(8'h02); send_byte(8'hFF);
            idle(5);
        end
        // Reset in the middle of a packet, then a clean packet.
        send_byte(HEADER); send_byte(8'h00); send_byte(8'h01);
        idle(3);
        do_reset();
        send_pkt(8'h12, 8'h34, 8'h5A, 2, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 99);
            g = $urandom_range(0, 12);
            d = 8'($urandom);
            if ($urandom_range(0, 3) == 0) d = HEADER;
            if (r < 10) begin
                b = 8'($urandom);
                if (b == HEADER) b = 8'h00;
                send_byte(b);
                idle(g);
            end else if (r < 60) begin
                a = 16'($urandom_range(0, PIXELS - 1));
                send_pkt(a[15:8], a[7:0], d, g, 1'b0);
            end else if (r < 70) begin
                a = 16'($urandom_range(PIXELS, 65535));
                send_pkt(a[15:8], a[7:0], d, g, 1'b0);
            end else if (r < 78) begin
                a = 16'($urandom_range(0, PIXELS - 1));
                send_pkt(a[15:8], a[7:0], d, g, 1'b1);
            end else if (r < 86) begin
                send_byte(HEADER);
                k = $urandom_range(0, NB - 2);
                repeat (k) send_byte(8'($urandom));
                idle(TIMEOUT_CYC + $urandom_range(0, 3));
            end else begin
                a = 16'($urandom_range(0, PIXELS - 1));
                send_byte(HEADER);
                send_byte(a[15:8]);
                idle(TIMEOUT_CYC - 1 + $urandom_range(0, 1));
                send_byte(a[7:0]);
                send_byte(d);
                if (CHK) send_byte(a[15:8] ^ a[7:0] ^ d);
                idle(g);
            end
        end

        idle(TIMEOUT_CYC + 10);
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/uart_pixel_loader.md
Name: uart_pixel_loader

Overview:
- Downstream consumer of the UART byte receiver.
- Takes each received byte (8-bit data plus a one-cycle done pulse) and assembles fixed-format pixel-write packets.
- For each valid packet, issues one write strobe into the VGA frame-buffer RAM.
- Detects malformed packets (inter-byte timeout, out-of-range address and, optionally, checksum mismatch) and drops them without writing.

Parameters:
- PIXELS, 19200, number of addressable frame-buffer words (160x120); valid addresses are 0..PIXELS-1.
- ADDR_W, 16, width of the write address bus.
- HEADER, 8'h55, packet start byte.
- TIMEOUT_CYC, 1000, maximum clk cycles allowed between consecutive bytes of one packet (about 3 byte times at 1562500 baud, 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous active-high reset.
- rx_data  in  8  received byte; valid only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe, byte received.
- wr_en  out  1  one-cycle frame-buffer write strobe.
- wr_addr  out  ADDR_W  frame-buffer write address.
- wr_data  out  8  pixel value (RGB332).
- busy  out  1  high while a packet is in progress (state != IDLE).
- err  out  1  one-cycle pulse, packet dropped.
- err_code  out  2  reason for the last drop: 0 timeout, 1 address out of range, 2 checksum; held until the next err.
- pkt_cnt  out  16  count of successful writes; wraps 16'hFFFF -> 0.

Behaviour:
- Reset: one clock, synchronous, active-high (rst=1 sampled on the clk rising edge). Reset sets every output to 0 and the FSM to IDLE, and discards any partial packet.
- Packet byte order: HEADER, ADDR_H, ADDR_L, DATA, then CHK (CHK only with the optional feature).
- Address: {ADDR_H, ADDR_L} truncated to ADDR_W bits.
- FSM states: IDLE, GET_AH, GET_AL, GET_DATA, GET_CHK, COMMIT.
- IDLE: on rx_valid with rx_data==HEADER -> GET_AH. Any other byte is ignored silently (no err).
- GET_AH -> GET_AL -> GET_DATA: each advances on rx_valid and latches the byte.
- GET_DATA: on rx_valid, latch the byte, then go to GET_CHK if the feature is enabled, otherwise COMMIT.
- COMMIT (one cycle), address < PIXELS:
  - wr_en=1, wr_addr and wr_data driven, pkt_cnt+1.
  - Next state IDLE.
- COMMIT, address >= PIXELS: no write, err=1, err_code=1, next state IDLE.
- Write latency: wr_en is high exactly one cycle after the rx_valid of the final packet byte.
- wr_addr and wr_data hold their values until the next commit; they are 0 after reset.
- An rx_valid arriving during COMMIT is not lost: it is evaluated as a possible HEADER, exactly as in IDLE.
- A HEADER-valued byte received mid-packet is treated as data, not as a resync.
- Timeout counter:
  - Cleared on every rx_valid and in IDLE; increments in all other states.
  - When it reaches TIMEOUT_CYC-1 with no rx_valid that cycle: next state IDLE, err=1, err_code=0.
  - If rx_valid and the timeout terminal count occur in the same cycle, rx_valid wins: the byte is accepted and the counter is cleared.
- busy=1 in every state except IDLE; it is registered and changes with the state.
- err and wr_en are never high in the same cycle.

Optional Feature:
- Macro: UART_PIXEL_CHK_EN.
- Defined:
  - The packet carries a 5th byte, CHK = ADDR_H ^ ADDR_L ^ DATA.
  - GET_CHK waits for that byte. On match -> COMMIT. On mismatch -> IDLE, err=1, err_code=2, no write.
  - The timeout applies in GET_CHK.
- Not defined: GET_CHK is not built, the packet is 4 bytes, and err_code never takes value 2.

Test Plan:
- Reset, then bytes 55, 01, 2C, E3 (plus CHK CE if enabled), each one rx_valid pulse 32 cycles apart -> exactly one wr_en, wr_addr=300, wr_data=E3, pkt_cnt=1, err never high.
- Bytes 12, 55, 00, 05, 7F (plus CHK 7A) -> the leading 12 is ignored; write at addr 5, data 7F; no err.
- Bytes 55, 4B, 00, 11 (address 19200) -> no wr_en, err pulse with err_code=1, busy low the next cycle, pkt_cnt unchanged.
- Bytes 55, 00, then an idle gap of TIMEOUT_CYC cycles -> err pulse with err_code=0, return to IDLE; a following full packet 55, 00, 00, AA (plus CHK AA) writes addr 0, data AA.
- Timeout boundary: the third byte is sent on exactly the terminal-count cycle -> accepted, no err; the packet completes and writes.
- With UART_PIXEL_CHK_EN: 55, 00, 01, 02, CHK FF (correct value 03) -> no write, err_code=2. Also assert rst mid-packet after the ADDR_L byte -> all outputs 0, and the next full packet writes correctly.
